// File: rtl/unit_seeker_lock_fsm.sv
// Purpose : seeks the 2-bit sync header position in gearbox frames, locks after SYNC_MAX good headers, drops lock on BAD_MAX bad per window.
// Latency : buffer_dv at cycle N -> header evaluated in N+1 -> state/position updated on the edge ending N+1.
// Backpressure: none; buffer_dv only qualifies capture, idle cycles freeze all state and counters.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   gbox_buffer       full gearbox buffer; gbox_cnt selects the FRAME_W+1 bit view
//   buffer_dv         buffer valid (captures the view, arms one evaluation)
//   force_resync_i    synchronous restart to HUNT at INIT_POS (wins over evaluation)
//   is_synced         high while LOCKED
//   offset_pos        current header position under test
//   state_o           HUNT=0 VERIFY=1 LOCKED=2 SLIP=3
//   lock_loss_o       one-cycle pulse when lock is lost
//   slip_cnt_o        saturating count of slips
module unit_seeker_lock_fsm #(
  parameter int FRAME_W   = 66,
  parameter int BUF_W     = 194,
  parameter int CNT_W     = 6,
  parameter int INIT_POS  = 0,
  parameter int END_POS   = 65,
  parameter int POS_STEP  = 1,
  parameter int SYNC_MAX  = 16,
  parameter int BAD_MAX   = 4,
  parameter int WIN_LEN   = 64,
  parameter int SLIP_WAIT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUF_W-1:0]             gbox_buffer,
  input  logic [CNT_W-1:0]             gbox_cnt,
  input  logic                         buffer_dv,
  input  logic                         force_resync_i,
  output logic                         is_synced,
  output logic [$clog2(END_POS+1)-1:0] offset_pos,
  output logic [1:0]                   state_o,
  output logic                         lock_loss_o,
  output logic [15:0]                  slip_cnt_o
);

  localparam int POS_W  = $clog2(END_POS+1);
  localparam int SEL_W  = $clog2(BUF_W);
  localparam int HDR_W  = $clog2(FRAME_W+1);
  localparam int GOOD_W = $clog2(SYNC_MAX+1);
  localparam int BAD_W  = $clog2(BAD_MAX+1);
  localparam int WIN_W  = $clog2(WIN_LEN+1);
  // +2 keeps the width at least one bit when SLIP_WAIT is 0
  localparam int WAIT_W = $clog2(SLIP_WAIT+2);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_SLIP   = 2'd3;

  logic [FRAME_W:0]  r_window;
  logic              r_win_vld;
  logic [1:0]        r_state;
  logic [POS_W-1:0]  r_pos;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [BAD_W-1:0]  r_bad_cnt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [15:0]       r_slip_cnt;
  logic              r_lock_loss;

  logic [SEL_W-1:0]  w_sel_hi;
  logic [FRAME_W:0]  w_window_in;
  logic [HDR_W-1:0]  w_hdr_lo;
  logic [1:0]        w_hdr;
  logic              w_good;
  logic [31:0]       w_pos_sum;
  logic [GOOD_W-1:0] w_good_inc;
  logic [BAD_W-1:0]  w_bad_inc;

  logic [1:0]        w_state_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [BAD_W-1:0]  w_bad_nxt;
  logic [WIN_W-1:0]  w_win_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [15:0]       w_slip_nxt;
  logic              w_lock_loss_nxt;
  logic              w_slip_go;

  // gbox_cnt counts from the MSB end of the buffer
  assign w_sel_hi    = SEL_W'(BUF_W-1) - SEL_W'(gbox_cnt);
  assign w_window_in = gbox_buffer[w_sel_hi -: FRAME_W+1];

  assign w_hdr_lo = HDR_W'(r_pos);
  assign w_hdr    = {r_window[w_hdr_lo + HDR_W'(1)], r_window[w_hdr_lo]};
  assign w_good   = ^w_hdr;  // 01 or 10

  // 32-bit sum so the wrap compare cannot overflow at the position width
  assign w_pos_sum  = 32'(r_pos) + 32'(POS_STEP);
  assign w_good_inc = r_good_cnt + GOOD_W'(1);
  assign w_bad_inc  = r_bad_cnt + BAD_W'(!w_good);

  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_good_nxt      = r_good_cnt;
    w_bad_nxt       = r_bad_cnt;
    w_win_nxt       = r_win_cnt;
    w_wait_nxt      = r_wait_cnt;
    w_slip_nxt      = r_slip_cnt;
    w_lock_loss_nxt = 1'b0;
    w_slip_go       = 1'b0;

    if (force_resync_i) begin
      w_state_nxt = ST_HUNT;
      w_pos_nxt   = POS_W'(INIT_POS);
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
      w_win_nxt   = '0;
      w_wait_nxt  = '0;
    end else begin
      if (r_win_vld) begin
        case (r_state)
          ST_HUNT: begin
            if (!w_good) begin
              w_slip_go = 1'b1;
            end else if (SYNC_MAX <= 1) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
              w_win_nxt   = '0;
            end else begin
              w_state_nxt = ST_VERIFY;
              w_good_nxt  = GOOD_W'(1);
            end
          end
          ST_VERIFY: begin
            if (!w_good) begin
              w_slip_go = 1'b1;
            end else if (w_good_inc == GOOD_W'(SYNC_MAX)) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
              w_win_nxt   = '0;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end
          ST_LOCKED: begin
            // loss of lock is checked first so it beats a coinciding window end
            if (!w_good && (w_bad_inc == BAD_W'(BAD_MAX))) begin
              w_slip_go       = 1'b1;
              w_lock_loss_nxt = 1'b1;
            end else if (r_win_cnt == WIN_W'(WIN_LEN-1)) begin
              w_win_nxt = '0;
              w_bad_nxt = '0;
            end else begin
              w_win_nxt = r_win_cnt + WIN_W'(1);
              w_bad_nxt = w_bad_inc;
            end
          end
          ST_SLIP: begin
            if (SLIP_WAIT != 0) begin
              if (r_wait_cnt + WAIT_W'(1) == WAIT_W'(SLIP_WAIT)) begin
                w_state_nxt = ST_HUNT;
                w_wait_nxt  = '0;
              end else begin
                w_wait_nxt = r_wait_cnt + WAIT_W'(1);
              end
            end
          end
          default: w_state_nxt = ST_HUNT;
        endcase
      end

      // with no discard period SLIP lasts exactly one cycle, evaluation or not
      if ((SLIP_WAIT == 0) && (r_state == ST_SLIP)) begin
        w_state_nxt = ST_HUNT;
      end

      if (w_slip_go) begin
        w_state_nxt = ST_SLIP;
        w_pos_nxt   = (w_pos_sum > 32'(END_POS)) ? POS_W'(INIT_POS) : POS_W'(w_pos_sum);
        w_slip_nxt  = (r_slip_cnt == 16'hFFFF) ? r_slip_cnt : r_slip_cnt + 16'd1;
        w_wait_nxt  = '0;
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
        w_win_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_window    <= '0;
      r_win_vld   <= 1'b0;
      r_state     <= ST_HUNT;
      r_pos       <= POS_W'(INIT_POS);
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_win_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_slip_cnt  <= '0;
      r_lock_loss <= 1'b0;
    end else begin
      if (buffer_dv) begin
        r_window <= w_window_in;
      end
      r_win_vld   <= buffer_dv;
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_good_cnt  <= w_good_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_win_cnt   <= w_win_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_slip_cnt  <= w_slip_nxt;
      r_lock_loss <= w_lock_loss_nxt;
    end
  end

  assign is_synced   = (r_state == ST_LOCKED);
  assign offset_pos  = r_pos;
  assign state_o     = r_state;
  assign lock_loss_o = r_lock_loss;
  assign slip_cnt_o  = r_slip_cnt;

endmodule

// File: tb/tb_unit_seeker_lock_fsm.sv
// Scoreboard bench: the stimulus process pushes hand-computed expectations tagged with the
// clock cycle they apply to; a negedge monitor pops and compares them.
module tb_unit_seeker_lock_fsm;

  logic         clk_i;
  logic         rst_ni;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic         force_resync_i;
  logic         is_synced;
  logic [6:0]   offset_pos;
  logic [1:0]   state_o;
  logic         lock_loss_o;
  logic [15:0]  slip_cnt_o;

  // second instance: POS_STEP=2 fed with headers that are bad everywhere
  logic [193:0] b_buffer;
  logic [5:0]   b_cnt;
  logic         b_dv;
  logic         b_force;
  logic         b_synced;
  logic [6:0]   b_pos;
  logic [1:0]   b_state;
  logic         b_loss;
  logic [15:0]  b_slips;

  unit_seeker_lock_fsm u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gbox_buffer(gbox_buffer), .gbox_cnt(gbox_cnt),
    .buffer_dv(buffer_dv), .force_resync_i(force_resync_i), .is_synced(is_synced),
    .offset_pos(offset_pos), .state_o(state_o), .lock_loss_o(lock_loss_o),
    .slip_cnt_o(slip_cnt_o)
  );

  unit_seeker_lock_fsm #(.POS_STEP(2)) u_dut_step2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .gbox_buffer(b_buffer), .gbox_cnt(b_cnt),
    .buffer_dv(b_dv), .force_resync_i(b_force), .is_synced(b_synced),
    .offset_pos(b_pos), .state_o(b_state), .lock_loss_o(b_loss),
    .slip_cnt_o(b_slips)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [95:0] nm;
    logic [1:0]  st;
    logic [6:0]  pos;
    logic        sy;
    logic        ll;
    logic [15:0] sl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_entry(input exp_t e);
    logic [1:0]  a_st;
    logic [6:0]  a_pos;
    logic        a_sy;
    logic        a_ll;
    logic [15:0] a_sl;
    if (e.dut == 0) begin
      a_st = state_o; a_pos = offset_pos; a_sy = is_synced; a_ll = lock_loss_o; a_sl = slip_cnt_o;
    end else begin
      a_st = b_state; a_pos = b_pos; a_sy = b_synced; a_ll = b_loss; a_sl = b_slips;
    end
    n_checks++;
    if (e.cyc != cyc) begin
      n_fail++;
      $display("FAIL %0s: check due at cycle %0d was not evaluated (now %0d)", e.nm, e.cyc, cyc);
    end else if (a_st !== e.st || a_pos !== e.pos || a_sy !== e.sy || a_ll !== e.ll || a_sl !== e.sl) begin
      n_fail++;
      $display("FAIL %0s cyc %0d: got st=%0d pos=%0d sync=%0b loss=%0b slips=%0d, want st=%0d pos=%0d sync=%0b loss=%0b slips=%0d",
               e.nm, cyc, a_st, a_pos, a_sy, a_ll, a_sl, e.st, e.pos, e.sy, e.ll, e.sl);
    end
  endtask

  // monitor: compare every expectation whose cycle has come
  always @(negedge clk_i) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        check_entry(sb_q[i]);
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int d, input logic [95:0] nm, input logic [1:0] st,
                           input logic [6:0] pos, input logic sy, input logic ll, input logic [15:0] sl);
    exp_t e;
    e.cyc = c; e.dut = d; e.nm = nm; e.st = st; e.pos = pos; e.sy = sy; e.ll = ll; e.sl = sl;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // good frame: window bits 0..5 set, so only position 5 sees 01; bad frame: window all zero.
  // Bits outside the selected view are ones so a wrong view index shows up as bad headers.
  function automatic logic [193:0] mk(input bit good, input logic [5:0] cnt);
    logic [66:0]  w;
    logic [193:0] win_sh;
    logic [193:0] mask_sh;
    w       = good ? 67'h3F : 67'h0;
    win_sh  = {w, 127'b0} >> cnt;
    mask_sh = {{67{1'b1}}, 127'b0} >> cnt;
    return win_sh | ~mask_sh;
  endfunction

  task automatic drive(input bit good, input logic [5:0] cnt);
    gbox_cnt    = cnt;
    gbox_buffer = mk(good, cnt);
    buffer_dv   = 1'b1;
  endtask

  function automatic bit is_bad_eval(input int j);
    return (j == 2) || (j == 62) || (j == 64) || (j == 65) || (j == 66) || (j == 70) || (j == 71);
  endfunction

  initial begin
    int b;
    int b3;
    int b4;
    logic [5:0] cnt;
    rst_ni         = 1'b0;
    force_resync_i = 1'b0;
    drive(1'b1, 6'd0);
    b_buffer = '0;
    b_cnt    = '0;
    b_dv     = 1'b1;
    b_force  = 1'b0;

    wait_cyc(2);
    expect_at(2, 0, "reset", 2'd0, 7'd0, 1'b0, 1'b0, 16'd0);
    expect_at(2, 1, "reset_s2", 2'd0, 7'd0, 1'b0, 1'b0, 16'd0);
    wait_cyc(3);
    rst_ni = 1'b1;
    b  = cyc;
    b3 = b + 140;
    b4 = b3 + 135;

    // acquisition: three evaluations per slip, 16 good evaluations to lock
    expect_at(b+1,   0, "no_eval_e1", 2'd0, 7'd0, 1'b0, 1'b0, 16'd0);
    expect_at(b+2,   0, "slip1",      2'd3, 7'd1, 1'b0, 1'b0, 16'd1);
    expect_at(b+4,   0, "hunt_p1",    2'd0, 7'd1, 1'b0, 1'b0, 16'd1);
    expect_at(b+14,  0, "slip5",      2'd3, 7'd5, 1'b0, 1'b0, 16'd5);
    expect_at(b+16,  0, "hunt_p5",    2'd0, 7'd5, 1'b0, 1'b0, 16'd5);
    expect_at(b+17,  0, "verify",     2'd1, 7'd5, 1'b0, 1'b0, 16'd5);
    expect_at(b+31,  0, "pre_lock",   2'd1, 7'd5, 1'b0, 1'b0, 16'd5);
    expect_at(b+32,  0, "locked",     2'd2, 7'd5, 1'b1, 1'b0, 16'd5);
    // bad windows: 3 in window 1 (last one on window end), 2+2 in window 2
    expect_at(b+96,  0, "win1_3bad",  2'd2, 7'd5, 1'b1, 1'b0, 16'd5);
    expect_at(b+98,  0, "win_bound",  2'd2, 7'd5, 1'b1, 1'b0, 16'd5);
    expect_at(b+102, 0, "win2_3bad",  2'd2, 7'd5, 1'b1, 1'b0, 16'd5);
    expect_at(b+103, 0, "lock_loss",  2'd3, 7'd6, 1'b0, 1'b1, 16'd6);
    expect_at(b+104, 0, "loss_pulse", 2'd3, 7'd6, 1'b0, 1'b0, 16'd6);
    expect_at(b+105, 0, "rsync_slip", 2'd0, 7'd0, 1'b0, 1'b0, 16'd6);
    expect_at(b+135, 0, "relock_pre", 2'd1, 7'd5, 1'b0, 1'b0, 16'd11);
    expect_at(b+136, 0, "relocked",   2'd2, 7'd5, 1'b1, 1'b0, 16'd11);
    expect_at(b+140, 0, "lock_hold",  2'd2, 7'd5, 1'b1, 1'b0, 16'd11);
    expect_at(b+141, 0, "rsync_lock", 2'd0, 7'd0, 1'b0, 1'b0, 16'd11);
    // buffer_dv idle for 100 cycles with good_cnt=7
    expect_at(b3+23,  0, "verify_g7", 2'd1, 7'd5, 1'b0, 1'b0, 16'd16);
    expect_at(b3+60,  0, "dv0_hold",  2'd1, 7'd5, 1'b0, 1'b0, 16'd16);
    expect_at(b3+123, 0, "dv0_end",   2'd1, 7'd5, 1'b0, 1'b0, 16'd16);
    expect_at(b3+131, 0, "verify_g15",2'd1, 7'd5, 1'b0, 1'b0, 16'd16);
    expect_at(b3+132, 0, "lock_g16",  2'd2, 7'd5, 1'b1, 1'b0, 16'd16);
    // asynchronous reset in VERIFY
    expect_at(b4+24, 0, "mid_verify", 2'd1, 7'd5, 1'b0, 1'b0, 16'd21);
    expect_at(b4+25, 0, "async_rst",  2'd0, 7'd0, 1'b0, 1'b0, 16'd0);
    expect_at(b4+29, 0, "post_rst",   2'd0, 7'd0, 1'b0, 1'b0, 16'd0);
    // step-2 instance: slip k lands on edge b+3k-1 at pos 2k, wrapping past 65
    expect_at(b+92, 1, "s2_pos62",  2'd3, 7'd62, 1'b0, 1'b0, 16'd31);
    expect_at(b+95, 1, "s2_pos64",  2'd3, 7'd64, 1'b0, 1'b0, 16'd32);
    expect_at(b+97, 1, "s2_hunt64", 2'd0, 7'd64, 1'b0, 1'b0, 16'd32);
    expect_at(b+98, 1, "s2_wrap",   2'd3, 7'd0,  1'b0, 1'b0, 16'd33);

    // frame driven at cycle b+30+j is locked-window evaluation j
    for (int c = b; c <= b + 104; c++) begin
      wait_cyc(c);
      if (c >= b + 40 && c < b + 50)      cnt = 6'd7;
      else if (c >= b + 50 && c < b + 60) cnt = 6'd63;
      else                                cnt = 6'd0;
      drive(!is_bad_eval(c - b - 30), cnt);
      if (c == b + 104) force_resync_i = 1'b1;
    end
    wait_cyc(b + 105);
    force_resync_i = 1'b0;

    wait_cyc(b + 140);
    force_resync_i = 1'b1;
    wait_cyc(b + 141);
    force_resync_i = 1'b0;

    wait_cyc(b3 + 22);
    buffer_dv   = 1'b0;
    gbox_buffer = '1;
    wait_cyc(b3 + 122);
    drive(1'b1, 6'd0);

    wait_cyc(b3 + 135);
    force_resync_i = 1'b1;
    wait_cyc(b3 + 136);
    force_resync_i = 1'b0;

    wait_cyc(b4 + 25);
    #1;
    rst_ni = 1'b0;
    wait_cyc(b4 + 28);
    rst_ni = 1'b1;
    wait_cyc(b4 + 31);

    while (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %0s: check due at cycle %0d never evaluated", sb_q[0].nm, sb_q[0].cyc);
      sb_q.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unit_seeker_lock_fsm.md
UNIT_SEEKER_LOCK_FSM -- requirements
Module: unit_seeker_lock_fsm

Interface
REQ-001 Parameters SHALL be FRAME_W=66, BUF_W=194, CNT_W=6, INIT_POS=0, END_POS=65, POS_STEP=1, SYNC_MAX=16, BAD_MAX=4, WIN_LEN=64, SLIP_WAIT=2.
- FRAME_W: frame width in bits.
- BUF_W: gearbox buffer width.
- CNT_W: width of gbox_cnt.
- INIT_POS / END_POS / POS_STEP: seeker position range and step.
- SYNC_MAX: consecutive good headers needed to lock.
- BAD_MAX: bad headers per window that cause loss of lock.
- WIN_LEN: monitoring window length, in evaluations.
- SLIP_WAIT: evaluations discarded after each slip.

REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-low.

REQ-003 Ports (name, direction, width, meaning):
- clk_i  in  1  system clock.
- rst_ni  in  1  async active-low reset.
- gbox_buffer  in  BUF_W  complete gearbox buffer.
- gbox_cnt  in  CNT_W  buffer view window index.
- buffer_dv  in  1  buffer data valid.
- force_resync_i  in  1  synchronous restart request.
- is_synced  out  1  lock indication.
- offset_pos  out  clog2(END_POS+1)  current seeker position.
- state_o  out  2  FSM state.
- lock_loss_o  out  1  one-cycle pulse on loss of lock.
- slip_cnt_o  out  16  saturating slip count.

REQ-004 Legal parameters SHALL satisfy END_POS+1 <= FRAME_W, INIT_POS <= END_POS, POS_STEP >= 1, and 1 <= BAD_MAX <= WIN_LEN. Legal gbox_cnt SHALL be <= BUF_W-FRAME_W-1.

Function
REQ-005 On a cycle with buffer_dv=1, the window register SHALL capture gbox_buffer[BUF_W-1-gbox_cnt -: FRAME_W+1], and win_vld SHALL register buffer_dv every cycle.

REQ-006 Header = window[pos+1 -: 2]. The header is good if it equals 2'b01 or 2'b10; otherwise it is bad.

REQ-007 An "evaluation" SHALL occur only on cycles with win_vld=1. With no evaluation, no state, counter or position SHALL change.

REQ-008 States and encodings:
- HUNT=0
- VERIFY=1
- LOCKED=2
- SLIP=3

REQ-009 HUNT:
- good -> VERIFY with good_cnt=1.
- bad -> SLIP.

REQ-010 VERIFY:
- good -> good_cnt+1.
- good_cnt reaching SYNC_MAX -> LOCKED, with good_cnt, bad_cnt and win_cnt cleared.
- bad -> SLIP with good_cnt=0.

REQ-011 SLIP entry (same clock edge):
- pos <= (pos+POS_STEP > END_POS) ? INIT_POS : pos+POS_STEP.
- slip_cnt_o increments, saturating at 16'hFFFF.
- wait_cnt <= 0.

REQ-012 SLIP: the next SLIP_WAIT evaluations SHALL be discarded (header ignored), then the FSM SHALL go to HUNT. If SLIP_WAIT=0, the next cycle SHALL go to HUNT.

REQ-013 LOCKED: each evaluation increments win_cnt, and a bad header increments bad_cnt.
- If bad_cnt reaches BAD_MAX -> SLIP, and lock_loss_o pulses 1 for one cycle.
- Else, when win_cnt reaches WIN_LEN-1, win_cnt and bad_cnt clear and the FSM stays LOCKED.

REQ-014 If the BAD_MAX-th bad header and window end coincide, loss of lock SHALL take priority.

REQ-015 force_resync_i=1 SHALL take priority over any evaluation. On the next edge:
- state=HUNT, pos=INIT_POS.
- good, bad, win and wait counters cleared.
- slip_cnt_o unchanged, lock_loss_o=0.

REQ-016 Output decode:
- is_synced = (state==LOCKED), decoded directly from the state register with no extra latency.
- offset_pos = pos register.
- state_o = state register.

REQ-017 Latency SHALL be as follows:
- buffer_dv high at cycle N -> evaluation at N+1 -> state/pos updated at edge ending N+1.
- Minimum lock time from HUNT with aligned data = SYNC_MAX evaluations.

REQ-018 All counters SHALL be wide enough for their maxima. Arithmetic SHALL NOT overflow; pos wrap uses the compare in REQ-011 at full width.

Reset
REQ-019 While rst_ni=0, the following SHALL be forced asynchronously:
- state=HUNT, pos=INIT_POS.
- window=0, win_vld=0.
- all counters 0.
- is_synced=0, lock_loss_o=0, slip_cnt_o=0, offset_pos=INIT_POS.

REQ-020 Reset deassertion SHALL be synchronised externally. The first evaluation SHALL occur no earlier than the second edge after release.

REQ-021 Reset asserted mid-operation (any state) SHALL abandon all progress, with no partial lock retained.

Verification
REQ-022 Defaults, headers aligned at pos 5, buffer_dv=1 continuously -> five SLIPs (pos 0->5, slip_cnt_o=5); after 16 good evaluations is_synced=1 and offset_pos=5.

REQ-023 Locked at pos 5: inject 3 bad headers in one 64-evaluation window -> stays LOCKED, is_synced=1. Inject 4 in one window -> lock_loss_o pulses once, state_o=3, offset_pos=6, slip_cnt_o increments.

REQ-024 POS_STEP=2, END_POS=65, pos=64, bad header -> offset_pos=0 (wrap); at pos=62, bad header -> 64.

REQ-025 buffer_dv held 0 for 100 cycles in VERIFY with good_cnt=7 -> state_o=1 and good_cnt=7 unchanged; lock completes after 9 further good evaluations.

REQ-026 force_resync_i pulsed while LOCKED at pos 5 -> next cycle state_o=0, offset_pos=0, is_synced=0, slip_cnt_o unchanged.

REQ-027 rst_ni low asynchronously mid-VERIFY (between clock edges) -> all outputs take their reset values immediately, before the next edge.
